// File: rtl/tune_player.sv
// Piezo tune sequencer: three ROM tunes of square-wave tones and rests, with abort, busy and done.
// Optional `loop` input (endless replay) is built when TUNE_LOOP_EN is defined.
module tune_player #(
  parameter int unsigned FAST_SIM    = 0,
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned DUR_W       = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [1:0] tune_sel,
  input  logic       abort,
`ifdef TUNE_LOOP_EN
  input  logic       loop,
`endif
  output logic       busy,
  output logic       done,
  output logic       piezo,
  output logic       piezo_n
);

  localparam int unsigned HALF_W = 16;
  localparam int unsigned IDX_W  = 3;

  localparam logic [DUR_W-1:0] DUR_INC = DUR_W'((FAST_SIM != 0) ? 16 : 1);

  // Rounded half-period in clocks: round(CLK / (2*f)).
  function automatic logic [HALF_W-1:0] half_of(input int unsigned f_hz);
    return HALF_W'((CLK_FREQ_HZ + f_hz) / (2 * f_hz));
  endfunction

  localparam logic [HALF_W-1:0] H_A5 = half_of(880);
  localparam logic [HALF_W-1:0] H_G6 = half_of(1568);
  localparam logic [HALF_W-1:0] H_C7 = half_of(2093);
  localparam logic [HALF_W-1:0] H_E7 = half_of(2637);
  localparam logic [HALF_W-1:0] H_G7 = half_of(3136);

  localparam logic [DUR_W-1:0] D22    = DUR_W'(32'd1 << 22);
  localparam logic [DUR_W-1:0] D23    = DUR_W'(32'd1 << 23);
  localparam logic [DUR_W-1:0] D24    = DUR_W'(32'd1 << 24);
  localparam logic [DUR_W-1:0] D23P22 = DUR_W'((32'd1 << 23) + (32'd1 << 22));

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_tune,  w_tune_nxt;
  logic [IDX_W-1:0]   r_idx,   w_idx_nxt;
  logic [DUR_W-1:0]   r_dur,   w_dur_nxt;
  logic [HALF_W-1:0]  r_frq,   w_frq_nxt;
  logic               w_piezo_nxt, w_busy_nxt, w_done_nxt;

  logic [HALF_W-1:0]  w_half;
  logic [DUR_W-1:0]   w_dur;
  logic               w_rest, w_last;
  logic [DUR_W:0]     w_dur_sum;
  logic               w_note_end, w_start, w_loop;

`ifdef TUNE_LOOP_EN
  assign w_loop = loop;
`else
  assign w_loop = 1'b0;
`endif

  assign w_start    = go && (tune_sel != 2'd3);
  assign w_dur_sum  = {1'b0, r_dur} + {1'b0, DUR_INC};
  assign w_note_end = (w_dur_sum >= {1'b0, w_dur});

  // Tune ROM: current note's half-period, duration, rest and end flags.
  always_comb begin
    w_half = '0;
    w_dur  = D22;
    w_rest = 1'b0;
    w_last = 1'b0;
    case (r_tune)
      2'd0: begin
        case (r_idx)
          3'd0:    begin w_half = H_G6; w_dur = D23;    end
          3'd1:    begin w_half = H_C7; w_dur = D23;    end
          3'd2:    begin w_half = H_E7; w_dur = D23;    end
          3'd3:    begin w_half = H_G7; w_dur = D23P22; end
          3'd4:    begin w_half = H_E7; w_dur = D22;    end
          default: begin w_half = H_G7; w_dur = D24; w_last = 1'b1; end
        endcase
      end
      2'd1: begin
        case (r_idx)
          3'd0:    begin w_half = H_A5; w_dur = D23; end
          3'd1:    begin w_rest = 1'b1; w_dur = D22; end
          default: begin w_half = H_A5; w_dur = D23; w_last = 1'b1; end
        endcase
      end
      default: begin
        case (r_idx)
          3'd0:    begin w_half = H_C7; w_dur = D22; end
          default: begin w_half = H_G7; w_dur = D22; w_last = 1'b1; end
        endcase
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; abort has priority over natural completion.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_nxt = S_PLAY;
      S_PLAY: begin
        if (abort)                             w_state_nxt = S_IDLE;
        else if (w_note_end && w_last && !w_loop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    w_tune_nxt  = r_tune;
    w_idx_nxt   = r_idx;
    w_dur_nxt   = r_dur;
    w_frq_nxt   = r_frq;
    w_piezo_nxt = piezo;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = (w_state_nxt == S_PLAY);
    case (r_state)
      S_IDLE: begin
        w_piezo_nxt = 1'b0;
        if (w_start) begin
          w_tune_nxt = tune_sel;
          w_idx_nxt  = '0;
          w_dur_nxt  = '0;
          w_frq_nxt  = '0;
        end
      end
      S_PLAY: begin
        if (abort) begin
          w_idx_nxt   = '0;
          w_dur_nxt   = '0;
          w_frq_nxt   = '0;
          w_piezo_nxt = 1'b0;
        end else if (w_note_end) begin
          w_dur_nxt   = '0;
          w_frq_nxt   = '0;
          w_piezo_nxt = 1'b0;
          w_idx_nxt   = w_last ? '0 : r_idx + IDX_W'(1);
          w_done_nxt  = w_last && !w_loop;
        end else begin
          w_dur_nxt = r_dur + DUR_INC;
          if (!w_rest) begin
            if (r_frq == w_half - HALF_W'(1)) begin
              w_frq_nxt   = '0;
              w_piezo_nxt = ~piezo;
            end else begin
              w_frq_nxt = r_frq + HALF_W'(1);
            end
          end
        end
      end
      default: w_piezo_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tune  <= '0;
      r_idx   <= '0;
      r_dur   <= '0;
      r_frq   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      piezo   <= 1'b0;
      piezo_n <= 1'b1;
    end else begin
      r_tune  <= w_tune_nxt;
      r_idx   <= w_idx_nxt;
      r_dur   <= w_dur_nxt;
      r_frq   <= w_frq_nxt;
      busy    <= w_busy_nxt;
      done    <= w_done_nxt;
      piezo   <= w_piezo_nxt;
      piezo_n <= ~w_piezo_nxt;
    end
  end

endmodule
